// File: rtl/heap_sequencer.sv
// rtl/heap_sequencer.sv - request FIFO and issue/capture sequencer in front of the heap Memory block
// Requests are queued, issued one at a time as action/array pairs, and returned as tagged responses.

module heap_sequencer_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_pop,
   output logic [WIDTH-1:0] rd_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push;
   logic             pop;

   assign wr_ready = (count_q != CNT_W'(DEPTH));
   assign rd_valid = (count_q != '0);
   assign rd_data  = mem_q[rd_ptr_q];
   assign push     = wr_valid && wr_ready;
   assign pop      = rd_pop && rd_valid;

   // Pointers are PTR_W bits wide, so DEPTH being a power of two makes them wrap naturally.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

module heap_sequencer #(
   parameter int          ADDRESS_BITS = 2,
   parameter int          DATA_BITS    = 12,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [7:0]  ACT_SIZE     = 8'd4,
   parameter logic [7:0]  ACT_GREATER  = 8'd9
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [7:0]              req_action,
   input  logic [ADDRESS_BITS-1:0] req_array,
   output logic [7:0]              heap_action,
   output logic [ADDRESS_BITS-1:0] heap_array,
   input  logic [DATA_BITS-1:0]    heap_out,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [7:0]              rsp_action,
   output logic [DATA_BITS-1:0]    rsp_data,
   output logic                    rsp_error,
   output logic [15:0]             done_count,
   output logic                    busy
);

   localparam int EW = 8 + ADDRESS_BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              heap_action_q, heap_action_d;
   logic [ADDRESS_BITS-1:0] heap_array_q, heap_array_d;
   logic [7:0]              issued_action_q, issued_action_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [7:0]              rsp_action_q, rsp_action_d;
   logic [DATA_BITS-1:0]    rsp_data_q, rsp_data_d;
   logic                    rsp_error_q, rsp_error_d;
   logic [15:0]             done_count_q, done_count_d;

   logic                    fifo_valid;
   logic                    fifo_pop;
   logic [EW-1:0]           fifo_rd_data;
   logic [7:0]              head_action;
   logic [ADDRESS_BITS-1:0] head_array;
   logic                    head_legal;
   logic                    load;

   heap_sequencer_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .wr_valid (req_valid),
      .wr_ready (req_ready),
      .wr_data  ({req_action, req_array}),
      .rd_valid (fifo_valid),
      .rd_pop   (fifo_pop),
      .rd_data  (fifo_rd_data)
   );

   assign head_action = fifo_rd_data[EW-1 -: 8];
   assign head_array  = fifo_rd_data[ADDRESS_BITS-1:0];
   assign head_legal  = (head_action == ACT_SIZE) || (head_action == ACT_GREATER);

   always_comb begin
      state_d         = state_q;
      heap_action_d   = heap_action_q;
      heap_array_d    = heap_array_q;
      issued_action_d = issued_action_q;
      rsp_valid_d     = rsp_valid_q;
      rsp_action_d    = rsp_action_q;
      rsp_data_d      = rsp_data_q;
      rsp_error_d     = rsp_error_q;
      done_count_d    = done_count_q;
      load            = 1'b0;

      case (state_q)
         S_IDLE: begin
            load = fifo_valid;
         end
         S_ISSUE: begin
            heap_action_d = '0;
            state_d       = S_CAPTURE;
         end
         S_CAPTURE: begin
            rsp_data_d   = heap_out;
            rsp_action_d = issued_action_q;
            rsp_error_d  = 1'b0;
            rsp_valid_d  = 1'b1;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               done_count_d = done_count_q + 16'd1;
               rsp_valid_d  = 1'b0;
               state_d      = S_IDLE;
               load         = fifo_valid;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Loading the next entry overrides the handshake results so RESP chains without a bubble.
      if (load) begin
         if (head_legal) begin
            heap_action_d   = head_action;
            heap_array_d    = head_array;
            issued_action_d = head_action;
            state_d         = S_ISSUE;
         end else begin
            rsp_data_d   = '0;
            rsp_error_d  = 1'b1;
            rsp_action_d = head_action;
            rsp_valid_d  = 1'b1;
            state_d      = S_RESP;
         end
      end
   end

   assign fifo_pop = load;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         heap_action_q   <= '0;
         heap_array_q    <= '0;
         issued_action_q <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_action_q    <= '0;
         rsp_data_q      <= '0;
         rsp_error_q     <= 1'b0;
         done_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         heap_action_q   <= heap_action_d;
         heap_array_q    <= heap_array_d;
         issued_action_q <= issued_action_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_action_q    <= rsp_action_d;
         rsp_data_q      <= rsp_data_d;
         rsp_error_q     <= rsp_error_d;
         done_count_q    <= done_count_d;
      end
   end

   assign heap_action = heap_action_q;
   assign heap_array  = heap_array_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_action  = rsp_action_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_error   = rsp_error_q;
   assign done_count  = done_count_q;
   assign busy        = fifo_valid || (state_q != S_IDLE);

endmodule

// File: tb/tb_heap_sequencer.sv
// tb/tb_heap_sequencer.sv - directed self-checking bench for heap_sequencer
// A small registered Memory model answers Size/Greater; a monitor logs every response handshake.

module tb_heap_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_action;
   logic [1:0]  req_array;
   logic [7:0]  heap_action;
   logic [1:0]  heap_array;
   logic [11:0] heap_out = '0;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_action;
   logic [11:0] rsp_data;
   logic        rsp_error;
   logic [15:0] done_count;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int heap_back_to_back = 0;
   logic [7:0] prev_heap_action = '0;

   logic [11:0] sizes   [4];
   logic [11:0] greater [4];

   logic [7:0]  q_act  [$];
   logic [11:0] q_data [$];
   logic        q_err  [$];
   int          q_cyc  [$];

   heap_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_action  (req_action),
      .req_array   (req_array),
      .heap_action (heap_action),
      .heap_array  (heap_array),
      .heap_out    (heap_out),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_action  (rsp_action),
      .rsp_data    (rsp_data),
      .rsp_error   (rsp_error),
      .done_count  (done_count),
      .busy        (busy)
   );

   initial forever #5 clock = ~clock;

   always @(posedge clock) begin
      cyc = cyc + 1;
      if (heap_action == 8'd4)      heap_out <= sizes[heap_array];
      else if (heap_action == 8'd9) heap_out <= greater[heap_array];
   end

   always @(negedge clock) begin
      if (reset && rsp_valid && rsp_ready) begin
         q_act.push_back(rsp_action);
         q_data.push_back(rsp_data);
         q_err.push_back(rsp_error);
         q_cyc.push_back(cyc);
      end
      if (heap_action != 8'd0 && prev_heap_action != 8'd0) heap_back_to_back = heap_back_to_back + 1;
      prev_heap_action = heap_action;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_action = '0;
      req_array  = '0;
      rsp_ready  = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic push(input logic [7:0] act, input logic [1:0] arr);
      req_valid  = 1'b1;
      req_action = act;
      req_array  = arr;
      for (int i = 0; i < 50 && !req_ready; i++) tick();
      check("push_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int base, input int n);
      for (int i = 0; i < 100 && (q_act.size() - base) < n; i++) tick();
      check("rsp_count", 32'(q_act.size() - base), 32'(n));
   endtask

   logic [7:0]  bp_act  [6] = '{8'd4, 8'd9, 8'd4, 8'd9, 8'd4, 8'd9};
   logic [1:0]  bp_arr  [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
   logic [11:0] bp_data [6] = '{12'd1, 12'd5, 12'd2, 12'd6, 12'd0, 12'd7};

   initial begin
      int base;
      logic saw_valid;
      sizes   = '{12'd1, 12'd2, 12'd2, 12'd0};
      greater = '{12'd3, 12'd5, 12'd6, 12'd7};

      // reset defaults
      do_reset();
      check("rst_heap_action", 32'(heap_action), 32'd0);
      check("rst_heap_array", 32'(heap_array), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_action", 32'(rsp_action), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_error", 32'(rsp_error), 32'd0);
      check("rst_done_count", 32'(done_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);

      // reset while in CAPTURE
      rsp_ready = 1'b1;
      push(8'd4, 2'd1);
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_heap_action", 32'(heap_action), 32'd0);
      tick();
      reset = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         saw_valid = saw_valid | rsp_valid;
      end
      check("midrst_no_rsp", 32'(saw_valid), 32'd0);
      check("midrst_busy_after", 32'(busy), 32'd0);
      check("midrst_heap_after", 32'(heap_action), 32'd0);

      // single Size, latency t+3
      do_reset();
      rsp_ready = 1'b1;
      push(8'd4, 2'd1);
      check("single_t0_valid", 32'(rsp_valid), 32'd0);
      tick();
      check("single_issue_action", 32'(heap_action), 32'd4);
      check("single_issue_array", 32'(heap_array), 32'd1);
      tick();
      check("single_t2_heap_action", 32'(heap_action), 32'd0);
      check("single_t2_valid", 32'(rsp_valid), 32'd0);
      tick();
      check("single_t3_valid", 32'(rsp_valid), 32'd1);
      check("single_data", 32'(rsp_data), 32'd2);
      check("single_action", 32'(rsp_action), 32'd4);
      check("single_error", 32'(rsp_error), 32'd0);
      tick();
      check("single_done", 32'(done_count), 32'd1);
      check("single_valid_drop", 32'(rsp_valid), 32'd0);

      // back-to-back, ready held high
      do_reset();
      rsp_ready = 1'b1;
      base = q_act.size();
      push(8'd9, 2'd0);
      push(8'd4, 2'd2);
      push(8'd4, 2'd3);
      wait_rsp(base, 3);
      if (q_act.size() - base >= 3) begin
         check("b2b_data0", 32'(q_data[base]), 32'd3);
         check("b2b_act0", 32'(q_act[base]), 32'd9);
         check("b2b_data1", 32'(q_data[base+1]), 32'd2);
         check("b2b_data2", 32'(q_data[base+2]), 32'd0);
         check("b2b_act2", 32'(q_act[base+2]), 32'd4);
         check("b2b_gap01", 32'(q_cyc[base+1] - q_cyc[base]), 32'd3);
         check("b2b_gap12", 32'(q_cyc[base+2] - q_cyc[base+1]), 32'd3);
      end
      check("b2b_done", 32'(done_count), 32'd3);

      // FIFO full under backpressure
      do_reset();
      rsp_ready = 1'b0;
      base = q_act.size();
      for (int i = 0; i < 5; i++) push(bp_act[i], bp_arr[i]);
      check("bp_full_ready", 32'(req_ready), 32'd0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(rsp_data), 32'd1);
      req_valid  = 1'b1;
      req_action = bp_act[5];
      req_array  = bp_arr[5];
      tick();
      tick();
      check("bp_stall_ready", 32'(req_ready), 32'd0);
      check("bp_hold_data", 32'(rsp_data), 32'd1);
      check("bp_hold_action", 32'(rsp_action), 32'd4);
      rsp_ready = 1'b1;
      push(bp_act[5], bp_arr[5]);
      wait_rsp(base, 6);
      for (int i = 0; i < 6; i++) begin
         if (q_act.size() > base + i) begin
            check($sformatf("bp_data%0d", i), 32'(q_data[base+i]), 32'(bp_data[i]));
            check($sformatf("bp_act%0d", i), 32'(q_act[base+i]), 32'(bp_act[i]));
         end
      end
      check("bp_done", 32'(done_count), 32'd6);

      // illegal action, then a legal one
      do_reset();
      rsp_ready = 1'b0;
      base = q_act.size();
      push(8'd7, 2'd0);
      tick();
      check("ill_t1_heap_action", 32'(heap_action), 32'd0);
      tick();
      check("ill_t2_heap_action", 32'(heap_action), 32'd0);
      check("ill_valid", 32'(rsp_valid), 32'd1);
      check("ill_error", 32'(rsp_error), 32'd1);
      check("ill_data", 32'(rsp_data), 32'd0);
      check("ill_action", 32'(rsp_action), 32'd7);
      rsp_ready = 1'b1;
      push(8'd4, 2'd1);
      wait_rsp(base, 2);
      if (q_act.size() - base >= 2) begin
         check("ill_q_err0", 32'(q_err[base]), 32'd1);
         check("ill_q_act0", 32'(q_act[base]), 32'd7);
         check("ill_q_err1", 32'(q_err[base+1]), 32'd0);
         check("ill_q_data1", 32'(q_data[base+1]), 32'd2);
      end
      check("ill_done", 32'(done_count), 32'd2);

      // done_count wrap
      do_reset();
      rsp_ready = 1'b1;
      force dut.done_count_q = 16'hFFFF;
      #1 release dut.done_count_q;
      base = q_act.size();
      push(8'd4, 2'd2);
      wait_rsp(base, 1);
      check("wrap_done", 32'(done_count), 32'd0);

      check("heap_no_back_to_back", 32'(heap_back_to_back), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
